// File: rtl/up_counter.sv
// up_counter: free-running modulo-2^Size binary up-counter with synchronous active-low reset.
// Optional build macro COUNTER_WRAP_PULSE_EN adds a registered one-cycle wrap pulse output.
module up_counter #(
    parameter int Size = 5
) (
    input  logic            clock,
    input  logic            reset,
`ifdef COUNTER_WRAP_PULSE_EN
    output logic            wrap,
`endif
    output logic [Size-1:0] count
);

    generate
        if ((Size < 1) || (Size > 32)) begin : g_bad_size
            $error("up_counter: Size must be within 1..32");
        end
    endgenerate

    localparam logic [Size-1:0] zero_c = {Size{1'b0}};
    localparam logic [Size-1:0] inc_c  = Size'(1'b1);

    logic [Size-1:0] count_r;
    logic [Size-1:0] count_next_s;

    // Next value; the carry out of the MSB is dropped so the count wraps naturally
    always_comb begin
        count_next_s = count_r + inc_c;
    end

    // Count register; reset has priority over counting
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= zero_c;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

`ifdef COUNTER_WRAP_PULSE_EN
    localparam logic [Size-1:0] max_c = {Size{1'b1}};

    logic at_max_s;
    logic wrap_r;

    // Terminal-count decode: the next counting edge rolls over to zero
    always_comb begin
        at_max_s = (count_r == max_c);
    end

    // Wrap pulse only for a counting rollover, never for a reset-induced zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= at_max_s;
        end
    end

    assign wrap = wrap_r;
`endif

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: Size=5 main instance plus Size=1 and Size=8 sweep instances.
// Expected values are queued when stimulus is driven and popped after the following rising edge.
module tb_up_counter;

    logic       clock;
    logic       reset;
    logic [4:0] cnt5;
    logic [0:0] cnt1;
    logic [7:0] cnt8;
`ifdef COUNTER_WRAP_PULSE_EN
    logic       w5;
    logic       w1;
    logic       w8;
`endif

    up_counter #(.Size(5)) u_dut5 (
        .clock (clock),
        .reset (reset),
`ifdef COUNTER_WRAP_PULSE_EN
        .wrap  (w5),
`endif
        .count (cnt5)
    );

    up_counter #(.Size(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
`ifdef COUNTER_WRAP_PULSE_EN
        .wrap  (w1),
`endif
        .count (cnt1)
    );

    up_counter #(.Size(8)) u_dut8 (
        .clock (clock),
        .reset (reset),
`ifdef COUNTER_WRAP_PULSE_EN
        .wrap  (w8),
`endif
        .count (cnt8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [4:0] exp_count;
        logic       exp_wrap;
    } vec_t;

    typedef struct {
        logic [4:0] c5;
        logic [0:0] c1;
        logic [7:0] c8;
        logic       w5;
        logic       w1;
        logic       w8;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    int errors = 0;
    int checks = 0;

    logic [4:0] m5;
    logic [0:0] m1;
    logic [7:0] m8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge's worth of stimulus, queue the expectation, then compare after the edge.
    task automatic drive_and_expect(input logic rst, input logic [4:0] exp5, input logic expw5);
        exp_t e;
        exp_t got;
        @(negedge clock);
        reset = rst;
        e.c5 = exp5;
        e.w5 = expw5;
        e.w1 = rst && (m1 == 1'b1);
        e.w8 = rst && (m8 == 8'd255);
        e.c1 = rst ? m1 + 1'b1 : 1'b0;
        e.c8 = rst ? m8 + 8'd1 : 8'd0;
        m5 = exp5;
        m1 = e.c1;
        m8 = e.c8;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk("count5", {27'd0, cnt5}, {27'd0, got.c5});
        chk("count1", {31'd0, cnt1}, {31'd0, got.c1});
        chk("count8", {24'd0, cnt8}, {24'd0, got.c8});
`ifdef COUNTER_WRAP_PULSE_EN
        chk("wrap5", {31'd0, w5}, {31'd0, got.w5});
        chk("wrap1", {31'd0, w1}, {31'd0, got.w1});
        chk("wrap8", {31'd0, w8}, {31'd0, got.w8});
`endif
    endtask

    task automatic step(input logic rst);
        logic [4:0] e5;
        logic       ew5;
        ew5 = rst && (m5 == 5'd31);
        e5  = rst ? m5 + 5'd1 : 5'd0;
        drive_and_expect(rst, e5, ew5);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
        end
    endtask

    initial begin
        reset = 1'b0;

        vecs[0] = '{rst: 1'b0, exp_count: 5'd0, exp_wrap: 1'b0};
        vecs[1] = '{rst: 1'b0, exp_count: 5'd0, exp_wrap: 1'b0};
        for (int k = 1; k <= 10; k++) begin
            vecs[k + 1] = '{rst: 1'b1, exp_count: 5'(k), exp_wrap: 1'b0};
        end

        m5 = 5'd0;
        m1 = 1'b0;
        m8 = 8'd0;

        // Reset from unknown state, then 1..10
        for (int i = 0; i < 12; i++) begin
            drive_and_expect(vecs[i].rst, vecs[i].exp_count, vecs[i].exp_wrap);
        end

        // Climb to all-ones, then wrap to 0 and resume at 1
        run(21);
        chk("count5_at_max", {27'd0, cnt5}, 32'd31);
        step(1'b1);
        chk("count5_wrapped", {27'd0, cnt5}, 32'd0);
        step(1'b1);

        // Mid-count reset at 17
        run(16);
        chk("count5_at_17", {27'd0, cnt5}, 32'd17);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        chk("count5_after_release", {27'd0, cnt5}, 32'd2);

        // Reset pulse between edges must not disturb count
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async_glitch_count5", {27'd0, cnt5}, 32'd2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("glitch_then_count5", {27'd0, cnt5}, 32'd3);
        m5 = 5'd3;
        m1 = m1 + 1'b1;
        m8 = m8 + 8'd1;

        // Reset at all-ones: forced to 0, no wrap pulse
        run(28);
        chk("count5_at_max_2", {27'd0, cnt5}, 32'd31);
        step(1'b0);
`ifdef COUNTER_WRAP_PULSE_EN
        chk("wrap5_after_reset_at_max", {31'd0, w5}, 32'd0);
`endif
        step(1'b1);

        // Long run so the 8-bit instance wraps 255 -> 0
        run(300);
        chk("count8_long_run", {24'd0, cnt8}, 32'd45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
